// File: rtl/fpbutterfly_post.sv
// Radix-2 butterfly back end: buffers operand A while the multiplier works,
// then pairs each product P with the oldest A and registers X0=A+P, X1=A-P.
module fpbutterfly_post #(
    parameter int n     = 32,
    parameter int d     = 16,
    parameter int DEPTH = 4,
    parameter int SCALE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       a_recv_val,
    output logic                       a_recv_rdy,
    input  logic [n-1:0]               ar,
    input  logic [n-1:0]               ac,
    input  logic                       p_recv_val,
    output logic                       p_recv_rdy,
    input  logic [n-1:0]               pr,
    input  logic [n-1:0]               pc,
    output logic                       send_val,
    input  logic                       send_rdy,
    output logic [n-1:0]               x0r,
    output logic [n-1:0]               x0c,
    output logic [n-1:0]               x1r,
    output logic [n-1:0]               x1c,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("fpbutterfly_post: DEPTH must be a power of two >= 2");
    end
    if ((d < 0) || (d >= n)) begin : g_bad_frac
        $error("fpbutterfly_post: d must lie in [0, n)");
    end

    logic [n-1:0]  mem_r [DEPTH];
    logic [n-1:0]  mem_c [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          fire;
    logic          ld;

    assign a_recv_rdy = (occupancy != DEPTH[AW:0]);
    assign ld         = !send_val || send_rdy;
    assign p_recv_rdy = (occupancy != '0) && ld;
    assign push       = a_recv_val && a_recv_rdy;
    assign fire       = p_recv_val && p_recv_rdy;

    // Storage has no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr] <= ar;
            mem_c[wr_ptr] <= ac;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (fire) rd_ptr <= rd_ptr + 1'b1;
            case ({push, fire})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    logic [n-1:0] head_r;
    logic [n-1:0] head_c;
    logic [n:0]   sum_r, sum_c, dif_r, dif_c;
    logic [n-1:0] res_x0r, res_x0c, res_x1r, res_x1c;

    assign head_r = mem_r[rd_ptr];
    assign head_c = mem_c[rd_ptr];

    // Sign-extend to n+1 bits so the scaled variant keeps the carry-out.
    assign sum_r = {head_r[n-1], head_r} + {pr[n-1], pr};
    assign sum_c = {head_c[n-1], head_c} + {pc[n-1], pc};
    assign dif_r = {head_r[n-1], head_r} - {pr[n-1], pr};
    assign dif_c = {head_c[n-1], head_c} - {pc[n-1], pc};

    assign res_x0r = (SCALE != 0) ? sum_r[n:1] : sum_r[n-1:0];
    assign res_x0c = (SCALE != 0) ? sum_c[n:1] : sum_c[n-1:0];
    assign res_x1r = (SCALE != 0) ? dif_r[n:1] : dif_r[n-1:0];
    assign res_x1c = (SCALE != 0) ? dif_c[n:1] : dif_c[n-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            send_val <= 1'b0;
            x0r      <= '0;
            x0c      <= '0;
            x1r      <= '0;
            x1c      <= '0;
        end else if (ld) begin
            send_val <= fire;
            if (fire) begin
                x0r <= res_x0r;
                x0c <= res_x0c;
                x1r <= res_x1r;
                x1c <= res_x1c;
            end
        end
    end
endmodule

// File: tb/tb_fpbutterfly_post.sv
// Scoreboard bench for fpbutterfly_post: two instances (SCALE=0 and SCALE=1)
// share one input stream; a reference model predicts handshakes and results.
module tb_fpbutterfly_post;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_recv_val = 1'b0, p_recv_val = 1'b0, send_rdy = 1'b0;
    logic [31:0] ar = '0, ac = '0, pr = '0, pc = '0;

    logic        a_rdy0, a_rdy1, p_rdy0, p_rdy1, sv0, sv1;
    logic [31:0] x0r0, x0c0, x1r0, x1c0, x0r1, x0c1, x1r1, x1c1;
    logic [2:0]  occ0, occ1;

    always #5 clk = ~clk;

    fpbutterfly_post #(.n(32), .d(16), .DEPTH(DEPTH), .SCALE(0)) dut0 (
        .clk(clk), .reset(reset),
        .a_recv_val(a_recv_val), .a_recv_rdy(a_rdy0), .ar(ar), .ac(ac),
        .p_recv_val(p_recv_val), .p_recv_rdy(p_rdy0), .pr(pr), .pc(pc),
        .send_val(sv0), .send_rdy(send_rdy),
        .x0r(x0r0), .x0c(x0c0), .x1r(x1r0), .x1c(x1c0), .occupancy(occ0));

    fpbutterfly_post #(.n(32), .d(16), .DEPTH(DEPTH), .SCALE(1)) dut1 (
        .clk(clk), .reset(reset),
        .a_recv_val(a_recv_val), .a_recv_rdy(a_rdy1), .ar(ar), .ac(ac),
        .p_recv_val(p_recv_val), .p_recv_rdy(p_rdy1), .pr(pr), .pc(pc),
        .send_val(sv1), .send_rdy(send_rdy),
        .x0r(x0r1), .x0c(x0c1), .x1r(x1r1), .x1c(x1c1), .occupancy(occ1));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference butterfly on plain integers: wrap for SCALE=0, floor-halve for SCALE=1.
    function automatic logic [31:0] bf(input logic [31:0] a, input logic [31:0] p,
                                       input bit sub, input bit scale);
        longint sa, sp, r;
        sa = longint'(signed'(a));
        sp = longint'(signed'(p));
        r  = sub ? (sa - sp) : (sa + sp);
        if (scale) r = r >>> 1;
        return r[31:0];
    endfunction

    typedef struct {
        logic [127:0] e0;
        logic [127:0] e1;
    } exp_t;

    logic [63:0] a_q[$];
    exp_t        exp_q[$];
    int          m_occ = 0;
    bit          m_sv  = 0;

    always @(negedge clk) begin
        bit   fire, push, prdy;
        exp_t e;
        logic [63:0] a;
        if (!reset) begin
            a_q.delete();
            exp_q.delete();
            m_occ = 0;
            m_sv  = 0;
        end else begin
            chk("occupancy", {125'(occ1), occ0}, {125'(m_occ[2:0]), m_occ[2:0]});
            chk("a_recv_rdy", {126'(a_rdy1), a_rdy0}, {126'(m_occ != DEPTH), (m_occ != DEPTH)});
            prdy = (m_occ != 0) && (!m_sv || send_rdy);
            chk("p_recv_rdy", {126'(p_rdy1), p_rdy0}, {126'(prdy), prdy});
            chk("send_val", {126'(sv1), sv0}, {126'(m_sv), m_sv});
            if (m_sv) begin
                if (exp_q.size() == 0) begin
                    chk("exp_queue_nonempty", 128'd0, 128'd1);
                end else begin
                    chk("x_scale0", {x0r0, x0c0, x1r0, x1c0}, exp_q[0].e0);
                    chk("x_scale1", {x0r1, x0c1, x1r1, x1c1}, exp_q[0].e1);
                    if (send_rdy) void'(exp_q.pop_front());
                end
            end
            fire = p_recv_val && prdy;
            push = a_recv_val && (m_occ != DEPTH);
            if (fire) begin
                a = a_q.pop_front();
                e.e0 = {bf(a[63:32], pr, 0, 0), bf(a[31:0], pc, 0, 0),
                        bf(a[63:32], pr, 1, 0), bf(a[31:0], pc, 1, 0)};
                e.e1 = {bf(a[63:32], pr, 0, 1), bf(a[31:0], pc, 0, 1),
                        bf(a[63:32], pr, 1, 1), bf(a[31:0], pc, 1, 1)};
                exp_q.push_back(e);
            end
            m_sv = fire || (m_sv && !send_rdy);
            if (push) a_q.push_back({ar, ac});
            m_occ = a_q.size();
        end
    end

    bit a_acc, p_acc;
    int n_a, n_p_off;

    task automatic step();
        @(negedge clk);
        a_acc = a_recv_val && a_rdy0;
        p_acc = p_recv_val && p_rdy0;
        @(posedge clk);
        #1;
        if (a_acc) begin n_a++; a_recv_val = 1'b0; end
        if (p_acc) p_recv_val = 1'b0;
    endtask

    task automatic push_a(input logic [31:0] r, input logic [31:0] c);
        int t = 0;
        a_recv_val = 1'b1; ar = r; ac = c;
        do begin step(); t++; end while (!a_acc && t < 50);
        if (!a_acc) begin chk("push_a_timeout", 128'd0, 128'd1); a_recv_val = 1'b0; end
    endtask

    task automatic send_p(input logic [31:0] r, input logic [31:0] c);
        int t = 0;
        p_recv_val = 1'b1; pr = r; pc = c;
        do begin step(); t++; end while (!p_acc && t < 50);
        if (!p_acc) begin chk("send_p_timeout", 128'd0, 128'd1); p_recv_val = 1'b0; end
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2;
        chk("reset_state", {occ0, sv0, a_rdy0, p_rdy0, x0r0, x0c0, x1r0, x1c0},
            {3'd0, 1'b0, 1'b1, 1'b0, 96'd0, 32'd0});
        @(posedge clk); #1;
        reset = 1'b1;
        send_rdy = 1'b1;

        // Basic pair
        push_a(32'h0001_0000, 32'h0000_8000);
        send_p(32'h0000_4000, 32'hFFFF_C000);
        chk("basic_pair", {31'd0, sv0, x0r0, x0c0, x1r0, x1c0},
            {31'd0, 1'b1, 32'h0001_4000, 32'h0000_4000, 32'h0000_C000, 32'h0000_C000});
        step();

        // Full, then drain, then product against an empty FIFO
        for (int i = 0; i < DEPTH; i++) push_a($urandom, $urandom);
        chk("full_state", {occ0, a_rdy0}, {3'd4, 1'b0});
        for (int i = 0; i < DEPTH; i++) send_p($urandom, $urandom);
        step();
        p_recv_val = 1'b1; pr = $urandom; pc = $urandom;
        for (int i = 0; i < 5; i++) begin
            chk("empty_stall", {126'd0, p_rdy0, p_rdy1}, 128'd0);
            step();
        end
        p_recv_val = 1'b0;

        // Back-pressure
        send_rdy = 1'b0;
        for (int i = 0; i < 3; i++) push_a(rnd_word(), rnd_word());
        send_p($urandom, $urandom);
        p_recv_val = 1'b1; pr = $urandom; pc = $urandom;
        for (int i = 0; i < 4; i++) step();
        chk("bp_one_fired", {occ0, p_rdy0, sv0}, {3'd2, 1'b0, 1'b1});
        send_rdy = 1'b1;
        step();
        chk("bp_second_fire", {127'd0, p_acc}, 128'd1);
        p_recv_val = 1'b1; pr = $urandom; pc = $urandom;
        step();
        chk("bp_third_fire", {127'd0, p_acc}, 128'd1);
        step();

        // Simultaneous push/pop at full and at occupancy 2
        for (int i = 0; i < DEPTH; i++) push_a($urandom, $urandom);
        a_recv_val = 1'b1; ar = $urandom; ac = $urandom;
        p_recv_val = 1'b1; pr = $urandom; pc = $urandom;
        chk("full_push_refused_rdy", {127'd0, a_rdy0}, 128'd0);
        step();
        chk("full_push_pop", {occ0, a_acc, p_acc}, {3'd3, 1'b0, 1'b1});
        a_recv_val = 1'b0;
        send_p($urandom, $urandom);
        a_recv_val = 1'b1; ar = $urandom; ac = $urandom;
        p_recv_val = 1'b1; pr = $urandom; pc = $urandom;
        step();
        chk("half_push_pop", {occ0, a_acc, p_acc}, {3'd2, 1'b1, 1'b1});
        for (int i = 0; i < 2; i++) send_p($urandom, $urandom);
        step();

        // SCALE=1 overflow corners
        push_a(32'h7FFF_FFFF, $urandom);
        send_p(32'h7FFF_FFFF, $urandom);
        chk("scale_max_sum", {x0r1, x1r1, x0r0, x1r0},
            {32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFE, 32'h0});
        push_a(32'h8000_0000, $urandom);
        send_p(32'h7FFF_FFFF, $urandom);
        chk("scale_min_diff", {64'd0, x1r1, x1r0}, {64'd0, 32'h8000_0000, 32'h0000_0001});
        step();

        // Randomized traffic
        n_a = 0; n_p_off = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!a_recv_val && $urandom_range(1)) begin
                a_recv_val = 1'b1; ar = rnd_word(); ac = rnd_word();
            end
            if (!p_recv_val && n_p_off < n_a && $urandom_range(1)) begin
                p_recv_val = 1'b1; pr = rnd_word(); pc = rnd_word(); n_p_off++;
            end
            send_rdy = ($urandom_range(3) != 0);
            step();
        end
        a_recv_val = 1'b0;
        send_rdy = 1'b1;
        for (int cyc = 0; cyc < 100 && (n_p_off < n_a || p_recv_val); cyc++) begin
            if (!p_recv_val && n_p_off < n_a) begin
                p_recv_val = 1'b1; pr = rnd_word(); pc = rnd_word(); n_p_off++;
            end
            step();
        end
        step(); step();
        chk("drain_complete", {occ0, sv0, 30'd0, 32'(exp_q.size())}, 67'd0);

        // Asynchronous reset mid-operation
        send_rdy = 1'b0;
        for (int i = 0; i < 3; i++) push_a($urandom, $urandom);
        send_p($urandom, $urandom);
        chk("pre_reset_state", {occ0, sv0}, {3'd2, 1'b1});
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_dut0", {occ0, sv0, x0r0, x0c0, x1r0, x1c0}, 132'd0);
        chk("async_reset_dut1", {occ1, sv1, x0r1, x0c1, x1r1, x1c1}, 132'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        send_rdy = 1'b1;
        push_a(32'h0000_1234, 32'hFFFF_FF00);
        send_p(32'h0000_0010, 32'h0000_0100);
        chk("post_reset_pair", {31'd0, sv0, x0r0, x0c0, x1r0, x1c0},
            {31'd0, 1'b1, 32'h0000_1244, 32'h0000_0000, 32'h0000_1224, 32'hFFFF_FE00});
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
